// File: rtl/pic_wr_ctrl_if.sv
// Port bundle for the picture-RAM write controller.
// The source side drives the byte stream and fill requests; the controller drives RAM port A.
interface pic_wr_ctrl_if #(
    parameter int unsigned ADDR_W = 15
);
    logic [7:0]        rx_data;
    logic              rx_flag;
    logic              fill_req;
    logic [7:0]        fill_color;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              busy;
    logic              frame_done;
    logic              load_err;
    logic [7:0]        frame_cnt;

    modport master (
        output rx_data, rx_flag, fill_req, fill_color,
        input  ram_we, ram_addr, ram_din, busy, frame_done, load_err, frame_cnt
    );

    modport slave (
        input  rx_data, rx_flag, fill_req, fill_color,
        output ram_we, ram_addr, ram_din, busy, frame_done, load_err, frame_cnt
    );
endinterface

// File: rtl/pic_wr_ctrl.sv
// Picture RAM write controller: locks onto a two-byte header, loads PIC_SIZE pixels from the
// serial byte stream into RAM port A, and shares that port with a solid-colour fill engine.
module pic_wr_ctrl #(
    parameter int unsigned PIC_SIZE = 29584,
    parameter int unsigned ADDR_W   = 15,
    parameter logic [7:0]  HDR0     = 8'h55,
    parameter logic [7:0]  HDR1     = 8'hAA,
    parameter int unsigned TIMEOUT  = 500000
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    pic_wr_ctrl_if.slave  bus
);

    localparam int unsigned       GapW     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PIC_SIZE - 1);
    localparam logic [GapW-1:0]   GapMax   = GapW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StHdr, StLoad, StFill} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        color_q, color_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [GapW-1:0]   gap_inc;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_din_q, ram_din_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              load_err_q, load_err_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    assign gap_inc = gap_q + GapW'(1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        color_d      = color_q;
        gap_d        = gap_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        frame_done_d = 1'b0;
        load_err_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.fill_req) begin
                    // Address 0 is written straight from the accept cycle, so the counter
                    // already points at the second pixel when FILL is entered.
                    color_d    = bus.fill_color;
                    ram_we_d   = 1'b1;
                    ram_addr_d = '0;
                    ram_din_d  = bus.fill_color;
                    if (LastAddr == '0) begin
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = StFill;
                        addr_d  = ADDR_W'(1);
                    end
                end else if (bus.rx_flag && bus.rx_data == HDR0) begin
                    state_d = StHdr;
                    gap_d   = '0;
                end
            end

            StHdr: begin
                if (bus.rx_flag) begin
                    gap_d = '0;
                    if (bus.rx_data == HDR1) begin
                        state_d = StLoad;
                        addr_d  = '0;
                    end else if (bus.rx_data != HDR0) begin
                        state_d = StIdle;
                    end
                end else if (gap_inc == GapMax) begin
                    state_d    = StIdle;
                    load_err_d = 1'b1;
                end else begin
                    gap_d = gap_inc;
                end
            end

            StLoad: begin
                if (bus.rx_flag) begin
                    gap_d      = '0;
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_q;
                    ram_din_d  = bus.rx_data;
                    if (addr_q == LastAddr) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                        state_d      = StIdle;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else if (gap_inc == GapMax) begin
                    state_d    = StIdle;
                    load_err_d = 1'b1;
                end else begin
                    gap_d = gap_inc;
                end
            end

            StFill: begin
                ram_we_d   = 1'b1;
                ram_addr_d = addr_q;
                ram_din_d  = color_q;
                if (addr_q == LastAddr) begin
                    frame_done_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            default: state_d = StIdle;
        endcase

        // busy covers the final write cycle; a timeout drops it together with load_err.
        busy_d = (state_d != StIdle) || frame_done_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            color_q      <= '0;
            gap_q        <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            load_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            color_q      <= color_d;
            gap_q        <= gap_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            load_err_q   <= load_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_din    = ram_din_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.load_err   = load_err_q;
    assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pic_wr_ctrl.sv
// Self-checking bench for pic_wr_ctrl: expected RAM writes are queued as stimulus is driven
// and popped by a monitor as the DUT writes.
module tb_pic_wr_ctrl;

    localparam int unsigned PS = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned TO = 20;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          done;
        logic [7:0]    fc;
    } wr_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   nvec      = 0;
    int   nerr      = 0;
    int   cyc       = 0;
    logic [7:0] exp_fc = 8'd0;
    wr_t  sb[$];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    pic_wr_ctrl_if #(.ADDR_W(AW)) bus ();

    pic_wr_ctrl #(
        .PIC_SIZE (PS),
        .ADDR_W   (AW),
        .HDR0     (8'h55),
        .HDR1     (8'hAA),
        .TIMEOUT  (TO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    // Write monitor: every ram_we cycle must match the head of the scoreboard.
    always @(negedge sys_clk) begin
        wr_t e;
        wr_t got;
        if (bus.ram_we === 1'b1) begin
            got = {bus.ram_addr, bus.ram_din, bus.frame_done, bus.frame_cnt};
            nvec++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write",
                         bus.ram_addr, bus.ram_din);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    nerr++;
                    $display("FAIL write: got addr=%0d data=%02h done=%0b cnt=%0d, required addr=%0d data=%02h done=%0b cnt=%0d",
                             got.addr, got.data, got.done, got.fc, e.addr, e.data, e.done, e.fc);
                end
            end
        end else if (bus.frame_done !== 1'b0) begin
            nvec++;
            nerr++;
            $display("FAIL stray_done: got frame_done=%0b without ram_we, required 0", bus.frame_done);
        end
    end

    task automatic push_exp(input int a, input logic [7:0] d, input bit last, input bit load);
        wr_t e;
        if (last && load) exp_fc = exp_fc + 8'd1;
        e = {AW'(a), d, last, exp_fc};
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        bus.rx_data = b;
        bus.rx_flag = 1'b1;
        @(negedge sys_clk);
        bus.rx_flag = 1'b0;
    endtask

    task automatic load_frame(input logic [7:0] seed, input bit b2b);
        logic [7:0] d;
        send_byte(8'h55);
        send_byte(8'hAA);
        for (int i = 0; i < int'(PS); i++) begin
            d = seed + 8'(i);
            push_exp(i, d, i == int'(PS) - 1, 1'b1);
            if (b2b) begin
                @(negedge sys_clk);
                bus.rx_data = d;
                bus.rx_flag = 1'b1;
            end else begin
                send_byte(d);
            end
        end
        if (b2b) begin
            @(negedge sys_clk);
            bus.rx_flag = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge sys_clk);
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        logic [AW+21:0] got;
        got = {bus.ram_we, bus.ram_addr, bus.ram_din, bus.busy, bus.frame_done, bus.load_err,
               bus.frame_cnt};
        nvec++;
        if (got !== '0) begin
            nerr++;
            $display("FAIL %s: got outputs=%h, required all zero", name, got);
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] req);
        nvec++;
        if (got !== req) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_idle_outputs("after_reset");
    endtask

    task automatic test_load();
        load_frame(8'h00, 1'b0);
        wait_drain("load");
        @(negedge sys_clk);
        check_val("load_frame_cnt", bus.frame_cnt, 8'd1);
        check_val("load_busy", {7'd0, bus.busy}, 8'd0);
    endtask

    task automatic test_hdr_resync();
        send_byte(8'h55);
        load_frame(8'h30, 1'b1);
        wait_drain("resync");
        check_val("resync_frame_cnt", bus.frame_cnt, exp_fc);
        send_byte(8'h55);
        send_byte(8'h12);
        check_val("bad_hdr_busy", {7'd0, bus.busy}, 8'd0);
        send_byte(8'hAA);
        send_byte(8'h99);
        repeat (3) @(negedge sys_clk);
        check_val("bad_hdr_idle", {7'd0, bus.busy}, 8'd0);
    endtask

    task automatic test_fill();
        int we_cnt = 0;
        for (int i = 0; i < int'(PS); i++) push_exp(i, 8'hE0, i == int'(PS) - 1, 1'b0);
        @(negedge sys_clk);
        bus.fill_color = 8'hE0;
        bus.fill_req   = 1'b1;
        for (int k = 0; k < int'(PS); k++) begin
            @(negedge sys_clk);
            bus.fill_req = 1'b0;
            bus.rx_data  = 8'h55;
            bus.rx_flag  = (k == 3 || k == 9);
            if (bus.ram_we === 1'b1) we_cnt++;
        end
        check_val("fill_we_cycles", 8'(we_cnt), 8'(PS));
        @(negedge sys_clk);
        check_val("fill_busy_drop", {6'd0, bus.busy, bus.ram_we}, 8'd0);
        wait_drain("fill");
        check_val("fill_frame_cnt", bus.frame_cnt, exp_fc);
        send_byte(8'hAA);
        send_byte(8'h44);
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_collision();
        for (int i = 0; i < int'(PS); i++) push_exp(i, 8'h3C, i == int'(PS) - 1, 1'b0);
        @(negedge sys_clk);
        bus.fill_color = 8'h3C;
        bus.fill_req   = 1'b1;
        bus.rx_data    = 8'h55;
        bus.rx_flag    = 1'b1;
        @(negedge sys_clk);
        bus.fill_req = 1'b0;
        bus.rx_flag  = 1'b0;
        wait_drain("collision");
        send_byte(8'hAA);
        send_byte(8'h77);
        repeat (3) @(negedge sys_clk);
        check_val("collision_busy", {7'd0, bus.busy}, 8'd0);
    endtask

    task automatic test_timeout();
        int t;
        int seen = -1;
        logic [7:0] fc0;
        fc0 = exp_fc;
        send_byte(8'h55);
        send_byte(8'hAA);
        for (int i = 0; i < 5; i++) begin
            push_exp(i, 8'hC0 + 8'(i), 1'b0, 1'b1);
            send_byte(8'hC0 + 8'(i));
        end
        t = cyc;
        for (int k = 0; k < 60 && seen < 0; k++) begin
            if (bus.load_err === 1'b1) begin
                seen = cyc;
                check_val("timeout_busy", {6'd0, bus.busy, bus.frame_done}, 8'd0);
            end else begin
                @(negedge sys_clk);
            end
        end
        nvec++;
        if (seen != t + int'(TO)) begin
            nerr++;
            $display("FAIL timeout_latency: got load_err at +%0d cycles, required +%0d",
                     seen - t, TO);
        end
        @(negedge sys_clk);
        check_val("timeout_pulse", {7'd0, bus.load_err}, 8'd0);
        wait_drain("timeout");
        check_val("timeout_frame_cnt", bus.frame_cnt, fc0);
    endtask

    task automatic test_wrap();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        sb.delete();
        exp_fc = 8'd0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int f = 0; f < 256; f++) begin
            load_frame(8'(f * 7), 1'b1);
            wait_drain("wrap");
            if (f == 254) check_val("wrap_255", bus.frame_cnt, 8'd255);
        end
        check_val("wrap_0", bus.frame_cnt, 8'd0);
    endtask

    task automatic test_reset_mid_load();
        int bad = 0;
        send_byte(8'h55);
        send_byte(8'hAA);
        for (int i = 0; i < 3; i++) begin
            push_exp(i, 8'h5A + 8'(i), 1'b0, 1'b1);
            send_byte(8'h5A + 8'(i));
        end
        wait_drain("mid_load");
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_load_reset");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (bus.frame_done !== 1'b0 || bus.load_err !== 1'b0) bad++;
        end
        check_val("mid_load_no_pulse", 8'(bad), 8'd0);
        send_byte(8'h11);
        repeat (2) @(negedge sys_clk);
        check_idle_outputs("mid_load_idle");
    endtask

    initial begin
        bus.rx_data    = 8'h00;
        bus.rx_flag    = 1'b0;
        bus.fill_req   = 1'b0;
        bus.fill_color = 8'h00;
        test_reset();
        test_load();
        test_hdr_resync();
        test_fill();
        test_collision();
        test_timeout();
        test_wrap();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1);
    end

endmodule
